// File: rtl/tone_sequencer_pkg.sv
// Shared types and default widths for the tone sequencer and its scaler wrapper.
package tone_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int SF_W_DEF  = 32;
  localparam int DUR_W_DEF = 8;

endpackage

// File: rtl/tone_sequencer_step_table.sv
// Step table: STEPS entries of {scale factor, duration}, one synchronous write
// port, one combinational read port, no reset so contents survive rst.
module tone_sequencer_step_table
  import tone_sequencer_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int SF_W  = SF_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  localparam int AW   = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SF_W-1:0]  wr_sf,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW-1:0]    rd_addr,
  output logic [SF_W-1:0]  rd_sf,
  output logic [DUR_W-1:0] rd_dur
);

  logic [SF_W-1:0]  sf_mem  [STEPS];
  logic [DUR_W-1:0] dur_mem [STEPS];

  // Out-of-range addresses are dropped when STEPS is not a power of two.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < STEPS)) begin
      sf_mem[wr_addr]  <= wr_sf;
      dur_mem[wr_addr] <= wr_dur;
    end
  end

  assign rd_sf  = sf_mem[rd_addr];
  assign rd_dur = dur_mem[rd_addr];

endmodule

// File: rtl/tone_sequencer.sv
// Steps a clock scaler through the programmed table, restarting the scaler
// (div_rst) for one cycle at every step boundary so each note starts at zero phase.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int SF_W  = SF_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  localparam int AW   = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SF_W-1:0]  wr_sf,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [AW-1:0]    last_idx,
  input  logic             tick,
  output logic [SF_W-1:0]  scale_factor,
  output logic             div_rst,
  output logic             note_on,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    last_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic [SF_W-1:0]  sf_q;
  logic             div_rst_q;
  logic             note_on_q;
  logic             busy_q;
  logic             done_q;

  logic [SF_W-1:0]  rd_sf;
  logic [DUR_W-1:0] rd_dur;
  logic [AW-1:0]    last_clamped;
  logic             at_last;
  logic             advance;

  tone_sequencer_step_table #(
    .STEPS (STEPS),
    .SF_W  (SF_W),
    .DUR_W (DUR_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_sf   (wr_sf),
    .wr_dur  (wr_dur),
    .rd_addr (idx_q),
    .rd_sf   (rd_sf),
    .rd_dur  (rd_dur)
  );

  assign last_clamped = (int'(last_idx) >= STEPS) ? AW'(STEPS - 1) : last_idx;
  assign at_last      = (idx_q == last_q);

  // A step ends either by being empty (zero duration, seen in LOAD) or by its final tick.
  always_comb begin
    advance = 1'b0;
    if (state_q == ST_LOAD) advance = (rd_dur == '0);
    if (state_q == ST_PLAY) advance = tick && (dur_cnt_q == DUR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      dur_cnt_q <= '0;
      sf_q      <= '0;
      div_rst_q <= 1'b1;
      note_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= ST_IDLE;
        div_rst_q <= 1'b1;
        note_on_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (advance) begin
        if (state_q == ST_PLAY) dur_cnt_q <= dur_cnt_q - DUR_W'(1);
        div_rst_q <= 1'b1;
        note_on_q <= 1'b0;
        if (!at_last) begin
          idx_q   <= idx_q + AW'(1);
          state_q <= ST_LOAD;
        end else if (loop) begin
          idx_q   <= '0;
          state_q <= ST_LOAD;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_LOAD;
              idx_q   <= '0;
              last_q  <= last_clamped;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            sf_q      <= rd_sf;
            dur_cnt_q <= rd_dur;
            state_q   <= ST_PLAY;
            div_rst_q <= 1'b0;
            note_on_q <= 1'b1;
          end
          ST_PLAY: begin
            if (tick) dur_cnt_q <= dur_cnt_q - DUR_W'(1);
          end
          default: begin
            state_q   <= ST_IDLE;
            div_rst_q <= 1'b1;
            note_on_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scale_factor = sf_q;
  assign div_rst      = div_rst_q;
  assign note_on      = note_on_q;
  assign step_idx     = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: expected notes (index, scale factor, tick count, lead-in
// LOAD cycles) and done pulses are queued from a table model and checked by a monitor.
module tb_tone_sequencer;

  localparam int STEPS = 6;
  localparam int AW    = 3;
  localparam int SF_W  = 32;
  localparam int DUR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [SF_W-1:0]  wr_sf;
  logic [DUR_W-1:0] wr_dur;
  logic             start;
  logic             stop;
  logic             loop;
  logic [AW-1:0]    last_idx;
  logic             tick;
  logic [SF_W-1:0]  scale_factor;
  logic             div_rst;
  logic             note_on;
  logic [AW-1:0]    step_idx;
  logic             busy;
  logic             done;

  tone_sequencer #(.STEPS(STEPS), .SF_W(SF_W), .DUR_W(DUR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_sf        (wr_sf),
    .wr_dur       (wr_dur),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .last_idx     (last_idx),
    .tick         (tick),
    .scale_factor (scale_factor),
    .div_rst      (div_rst),
    .note_on      (note_on),
    .step_idx     (step_idx),
    .busy         (busy),
    .done         (done)
  );

  // ---------------- clock / tick generation ----------------
  always #5 clk = ~clk;

  bit tick_en = 1'b0;
  int tper    = 4;
  int tcnt    = 0;

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick = (tcnt == 0);
        tcnt = (tcnt + 1 >= tper) ? 0 : tcnt + 1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] m_sf  [STEPS];
  logic [7:0]  m_dur [STEPS];
  int          m_last;
  int          pend_skips;
  logic [63:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  bit          abort_note = 1'b0;

  function automatic logic [63:0] mk(input bit kind, input int gap, input int idx,
                                     input logic [31:0] sf, input int dur);
    return {7'd0, kind, 8'(gap), 8'(idx), sf, 8'(dur)};
  endfunction

  function automatic int clamp_last(input int l);
    return (l >= STEPS) ? STEPS - 1 : l;
  endfunction

  // One pass over steps 0..m_last; empty steps only lengthen the next note's lead-in.
  function automatic void push_pass();
    for (int i = 0; i <= m_last; i++) begin
      if (m_dur[i] == 8'd0) begin
        pend_skips++;
      end else begin
        exp_q.push_back(mk(1'b0, pend_skips + 1, i, m_sf[i], int'(m_dur[i])));
        pend_skips = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit          prev_note = 1'b0;
  bit          prev_done = 1'b0;
  int          gap_cnt   = 0;
  int          note_gap  = 0;
  int          ticks     = 0;
  logic [31:0] cur_sf;
  int          cur_idx;
  logic [63:0] e;

  always @(negedge clk) begin
    if (busy === 1'b1 && note_on === 1'b0) gap_cnt++;
    else if (busy !== 1'b1) gap_cnt = 0;
    if (note_on === 1'b1 && !prev_note) begin
      cur_sf   = scale_factor;
      cur_idx  = int'(step_idx);
      ticks    = 0;
      note_gap = gap_cnt;
      gap_cnt  = 0;
    end
    if (note_on === 1'b1) begin
      check("play_outputs", {div_rst, busy, scale_factor}, {1'b0, 1'b1, cur_sf});
      if (tick) ticks++;
    end
    if (note_on === 1'b0 && prev_note) begin
      if (abort_note) begin
        abort_note = 1'b0;
      end else begin
        check("note_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("note", mk(1'b0, note_gap, cur_idx, cur_sf, ticks), e);
        end
      end
    end
    if (done === 1'b1) begin
      check("done_width", 64'(prev_done), 64'd0);
      check("done_outputs", {busy, note_on, div_rst}, 3'b001);
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("done_kind", 64'(e[56]), 64'd1);
      end
    end
    prev_done = (done === 1'b1);
    prev_note = (note_on === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int addr, input logic [31:0] sf, input logic [7:0] dur);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_sf   = sf;
    wr_dur  = dur;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < STEPS) begin
      m_sf[addr]  = sf;
      m_dur[addr] = dur;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_note_at(input int idx);
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (note_on === 1'b1 && int'(step_idx) == idx) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_note_at", 64'(ok), 64'd1);
  endtask

  task automatic wait_note_end();
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (note_on === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_note_end", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      if (busy === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_idle", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {scale_factor, div_rst, note_on, step_idx, busy, done},
          {32'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
  endtask

  // Full sequence: passes>1 runs with loop=1 and drops loop during the final pass's last step.
  task automatic run_seq(input int last_in, input int passes, input bit mid_write, input bit poke);
    m_last     = clamp_last(last_in);
    pend_skips = 0;
    last_idx   = AW'(last_in);
    loop       = (passes > 1);
    push_pass();
    if (passes == 1) exp_q.push_back(mk(1'b1, 0, 0, 32'd0, 0));
    pulse_start();
    last_idx = AW'($urandom_range(0, 7));
    if (poke) begin
      wait_note_at(0);
      pulse_start();
    end
    if (mid_write) begin
      wait_note_at(0);
      write_entry(0, 32'd999, m_dur[0]);
      write_entry(STEPS, 32'h1234_5678, 8'd7);
    end
    if (passes > 1) begin
      for (int p = 1; p <= passes; p++) begin
        wait_note_at(m_last);
        if (p == passes) begin
          loop = 1'b0;
          exp_q.push_back(mk(1'b1, 0, 0, 32'd0, 0));
        end else begin
          wait_note_end();
          push_pass();
        end
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_basic();
    write_entry(0, 32'd100, 8'd2);
    write_entry(1, 32'd200, 8'd1);
    write_entry(2, 32'd300, 8'd3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sf = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    for (int i = 0; i < STEPS; i++) write_entry(i, 32'(i + 1), 8'd1);
    load_basic();
    tick_en = 1'b1;
    tper    = 4;

    // basic pass, with a start pulse during play that must be ignored
    run_seq(2, 1, 1'b0, 1'b1);
    check("idle_after_done", {busy, div_rst, note_on, scale_factor}, {1'b0, 1'b1, 1'b0, 32'd300});

    // loop three passes, done at the end of the last
    run_seq(2, 3, 1'b0, 1'b0);

    // stop during step 1
    exp_q.push_back(mk(1'b0, 1, 0, 32'd100, 2));
    last_idx = 3'd2; loop = 1'b0;
    pulse_start();
    wait_note_at(1);
    stop = 1'b1; abort_note = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("after_stop", {busy, div_rst, note_on, done, scale_factor},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd200});
    repeat (12) @(negedge clk);
    check("stop_no_more", {64'(exp_q.size()), 8'(busy)}, {64'd0, 8'd0});

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_collision", {busy, div_rst, note_on}, 3'b010);
    @(negedge clk);
    check("start_stop_still_idle", 64'(busy), 64'd0);

    // zero-duration skip of step 1
    write_entry(1, 32'd200, 8'd0);
    run_seq(2, 1, 1'b0, 1'b0);
    write_entry(1, 32'd200, 8'd1);

    // write entry 0 while it plays; new value appears on the next pass only
    run_seq(2, 2, 1'b1, 1'b0);
    write_entry(0, 32'd100, 8'd2);

    // reset mid-sequence, then replay the retained table
    exp_q.push_back(mk(1'b0, 1, 0, 32'd100, 2));
    last_idx = 3'd2; loop = 1'b0;
    pulse_start();
    wait_note_at(1);
    rst = 1'b1; abort_note = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_mid_sequence");
    run_seq(2, 1, 1'b0, 1'b0);

    // last_idx beyond the table clamps to STEPS-1
    for (int i = 3; i < STEPS; i++) write_entry(i, 32'(1000 + i), 8'(i - 2));
    run_seq(7, 1, 1'b0, 1'b0);

    // randomized tables, lengths, tick rates and pass counts
    for (int r = 0; r < 10; r++) begin
      int last_r;
      int passes;
      for (int i = 0; i < STEPS; i++) write_entry(i, $urandom, 8'($urandom_range(0, 3)));
      tper   = $urandom_range(1, 4);
      last_r = $urandom_range(0, 7);
      passes = $urandom_range(1, 3);
      if (passes > 1 && m_dur[clamp_last(last_r)] == 8'd0)
        write_entry(clamp_last(last_r), m_sf[clamp_last(last_r)], 8'd1);
      run_seq(last_r, passes, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
